// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg
// Shared constants for the 3x3 matrix-multiply Wishbone system: the word
// addresses of the A, B and C matrices in the slave, the matrix geometry and
// the sequencer FSM state encoding. Used by mm_wb_sequencer and by the slave
// wrapper, so both sides agree on the memory map.
// ---------------------------------------------------------------------------
package mm_pkg;

    localparam int A_OFFSET  = 0;   // word address of A element 0
    localparam int B_OFFSET  = 9;   // word address of B element 0
    localparam int C_OFFSET  = 18;  // word address of C element 0
    localparam int MAT_SIZE  = 9;   // elements per matrix
    localparam int INT_WIDTH = 8;   // bits per element

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        WGAP   = 3'd2,
        READ   = 3'd3,
        RGAP   = 3'd4,
        FINISH = 3'd5
    } state_t;

endpackage

// File: rtl/mm_wb_sequencer.sv
// ---------------------------------------------------------------------------
// mm_wb_sequencer
// Wishbone master that runs one matrix-multiply job on a memory-mapped slave:
// writes the 9 elements of A and then the 9 elements of B (one element per
// word, in [7:0]), then reads back the 9 elements of C (element in [31:24]).
// Each transfer is stb high until ack, followed by a single gap cycle that
// absorbs the slave's registered, repeated ack. A slave error or a transfer
// waiting TIMEOUT cycles aborts the job. All outputs are registered.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a job; only sampled while idle
//   a_mat, b_mat      operand matrices, element i at [i*INT_WIDTH +: INT_WIDTH]
//   c_mat             result matrix, same packing; keeps elements read so far
//   busy              job in progress
//   done              one-cycle pulse at the end of every job
//   error             sticky abort flag, cleared by the next accepted start
//   cyc, stb, we, sel, adr, dat_mosi   Wishbone master request
//   dat_miso, ack, err                 Wishbone slave response
// ---------------------------------------------------------------------------
module mm_wb_sequencer
    import mm_pkg::*;
#(
    parameter int A_OFFSET  = mm_pkg::A_OFFSET,
    parameter int B_OFFSET  = mm_pkg::B_OFFSET,
    parameter int C_OFFSET  = mm_pkg::C_OFFSET,
    parameter int MAT_SIZE  = mm_pkg::MAT_SIZE,
    parameter int INT_WIDTH = mm_pkg::INT_WIDTH,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [MAT_SIZE*INT_WIDTH-1:0] a_mat,
    input  logic [MAT_SIZE*INT_WIDTH-1:0] b_mat,
    output logic [MAT_SIZE*INT_WIDTH-1:0] c_mat,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic                          cyc,
    output logic                          stb,
    output logic                          we,
    output logic [3:0]                    sel,
    output logic [31:0]                   adr,
    output logic [31:0]                   dat_mosi,
    input  logic [31:0]                   dat_miso,
    input  logic                          ack,
    input  logic                          err
);

    localparam int MW = MAT_SIZE * INT_WIDTH;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [4:0]    LAST_A    = 5'(MAT_SIZE - 1);
    localparam logic [4:0]    LAST_WR   = 5'(2 * MAT_SIZE - 1);
    localparam logic [4:0]    LAST_RD   = 5'(MAT_SIZE - 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    state_t          state, state_n;
    logic [4:0]      idx, idx_n;
    logic [CW-1:0]   wait_cnt, wait_cnt_n;
    logic [2*MW-1:0] ab_q, ab_n;

    logic            cyc_n, stb_n, we_n, busy_n, done_n, error_n;
    logic [3:0]      sel_n;
    logic [31:0]     adr_n, dat_n;
    logic [MW-1:0]   c_n;

    // Transfer outcome in WRITE/READ; err wins over a simultaneous ack.
    logic            in_xfer, xfer_fail, xfer_ok;
    logic [2*MW-1:0] wr_src;
    logic [31:0]     wr_adr, wr_dat, rd_adr;

    assign in_xfer   = (state == WRITE) || (state == READ);
    assign xfer_fail = in_xfer && (err || (!ack && wait_cnt == LAST_WAIT));
    assign xfer_ok   = in_xfer && !err && ack;

    // Request fields for the element the next transfer will address. On the
    // accepting cycle the operands are not latched yet, so take the ports.
    assign wr_src = (state == IDLE) ? {b_mat, a_mat} : ab_q;
    assign wr_adr = (idx_n <= LAST_A) ? 32'(A_OFFSET) + 32'(idx_n)
                                      : 32'(B_OFFSET) + 32'(idx_n) - 32'(MAT_SIZE);
    assign wr_dat = 32'(wr_src[idx_n*INT_WIDTH +: INT_WIDTH]);
    assign rd_adr = 32'(C_OFFSET) + 32'(idx_n);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_n    = state;
        idx_n      = idx;
        wait_cnt_n = '0;  // restarts on every stb rise
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = WRITE;
                    idx_n   = '0;
                end
            end
            WRITE, READ: begin
                if (xfer_fail)    state_n = FINISH;
                else if (xfer_ok) state_n = (state == WRITE) ? WGAP : RGAP;
                else              wait_cnt_n = wait_cnt + 1'b1;
            end
            WGAP: begin
                if (idx == LAST_WR) begin
                    state_n = READ;
                    idx_n   = '0;
                end else begin
                    state_n = WRITE;
                    idx_n   = idx + 1'b1;
                end
            end
            RGAP: begin
                if (idx == LAST_RD) begin
                    state_n = FINISH;
                end else begin
                    state_n = READ;
                    idx_n   = idx + 1'b1;
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ---------------- output logic (next values of output registers) -------
    always_comb begin
        cyc_n   = cyc;
        stb_n   = stb;
        we_n    = we;
        sel_n   = sel;
        adr_n   = adr;
        dat_n   = dat_mosi;
        busy_n  = busy;
        done_n  = 1'b0;
        error_n = error;
        c_n     = c_mat;
        ab_n    = ab_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    ab_n    = {b_mat, a_mat};
                    error_n = 1'b0;
                    busy_n  = 1'b1;
                    cyc_n   = 1'b1;
                    stb_n   = 1'b1;
                    we_n    = 1'b1;
                    sel_n   = 4'b0001;
                    adr_n   = wr_adr;
                    dat_n   = wr_dat;
                end
            end
            WRITE, READ: begin
                if (xfer_fail) begin
                    stb_n   = 1'b0;
                    cyc_n   = 1'b0;
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (xfer_ok) begin
                    stb_n = 1'b0;
                    if (state == READ)
                        c_n[idx*INT_WIDTH +: INT_WIDTH] = dat_miso[31 -: INT_WIDTH];
                end
            end
            WGAP: begin
                stb_n = 1'b1;
                if (state_n == WRITE) begin
                    adr_n = wr_adr;
                    dat_n = wr_dat;
                end else begin
                    we_n  = 1'b0;
                    sel_n = 4'b1111;
                    adr_n = rd_adr;
                    dat_n = '0;
                end
            end
            RGAP: begin
                if (state_n == READ) begin
                    stb_n = 1'b1;
                    adr_n = rd_adr;
                end else begin
                    cyc_n  = 1'b0;
                    busy_n = 1'b0;
                    done_n = 1'b1;
                end
            end
            default: ;  // FINISH: done drops back to its default
        endcase
    end

    // ---------------- output and datapath registers ----------------
    // NOTE: the result and operand registers are plain flops, not a RAM, so
    // they are cleared by reset like every other output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      <= 1'b0;
            stb      <= 1'b0;
            we       <= 1'b0;
            sel      <= '0;
            adr      <= '0;
            dat_mosi <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            c_mat    <= '0;
            ab_q     <= '0;
        end else begin
            cyc      <= cyc_n;
            stb      <= stb_n;
            we       <= we_n;
            sel      <= sel_n;
            adr      <= adr_n;
            dat_mosi <= dat_n;
            busy     <= busy_n;
            done     <= done_n;
            error    <= error_n;
            c_mat    <= c_n;
            ab_q     <= ab_n;
        end
    end

endmodule

// File: tb/tb_mm_wb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mm_wb_sequencer
// Drives mm_wb_sequencer against a registered Wishbone slave that stores A
// and B and answers reads of C with the 3x3 product (mod 256). The slave can
// be told to raise err on one write address or never answer one read
// address. Expected results come from a plain matrix-multiply model and from
// hand-written constants.
// ---------------------------------------------------------------------------
module tb_mm_wb_sequencer;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [71:0] a_mat = '0;
    logic [71:0] b_mat = '0;
    logic [71:0] c_mat;
    logic        busy, done, error, cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_mosi, dat_miso;
    logic        ack, err;

    always #5 clk = ~clk;

    mm_wb_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_mat    (a_mat),
        .b_mat    (b_mat),
        .c_mat    (c_mat),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cyc      (cyc),
        .stb      (stb),
        .we       (we),
        .sel      (sel),
        .adr      (adr),
        .dat_mosi (dat_mosi),
        .dat_miso (dat_miso),
        .ack      (ack),
        .err      (err)
    );

    // ---------------- slave model ----------------
    logic [7:0] mem [0:31];
    int         err_adr  = -1;
    int         hang_adr = -1;

    function automatic logic [7:0] slave_product(input int i);
        int s = 0;
        for (int k = 0; k < 3; k++)
            s += int'(mem[(i / 3) * 3 + k]) * int'(mem[9 + k * 3 + (i % 3)]);
        return 8'(s);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack      <= 1'b0;
            err      <= 1'b0;
            dat_miso <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (cyc && stb) begin
                if (we && int'(adr) == err_adr) begin
                    err <= 1'b1;
                end else if (we || int'(adr) != hang_adr) begin
                    ack <= 1'b1;
                    if (we) mem[adr[4:0]] <= dat_mosi[7:0];
                    else    dat_miso <= {slave_product(int'(adr) - 18), 24'h0};
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [31:0] xfer_log[$];
    int          done_cnt, cyc_cycles, rises, stb_run, last_stb_len;
    logic        stb_prev = 1'b0;

    always @(posedge clk) begin
        if (cyc && stb && ack && !err) xfer_log.push_back(adr);
        if (done) done_cnt++;
        if (cyc) cyc_cycles++;
        if (stb && !stb_prev) rises++;
        if (stb) stb_run++;
        else if (stb_run != 0) begin
            last_stb_len = stb_run;
            stb_run      = 0;
        end
        stb_prev = stb;
    end

    // ---------------- reference model ----------------
    function automatic logic [71:0] mat_mul(input logic [71:0] a, input logic [71:0] b);
        logic [71:0] c = '0;
        for (int r = 0; r < 3; r++)
            for (int col = 0; col < 3; col++) begin
                int s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'(a[(r * 3 + k) * 8 +: 8]) * int'(b[(k * 3 + col) * 8 +: 8]);
                c[(r * 3 + col) * 8 +: 8] = 8'(s);
            end
        return c;
    endfunction

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        xfer_log.delete();
        done_cnt     = 0;
        cyc_cycles   = 0;
        rises        = 0;
        stb_run      = 0;
        last_stb_len = 0;
    endtask

    // Called on a falling edge; returns one falling edge after acceptance.
    task automatic launch_job(input logic [71:0] a, input logic [71:0] b,
                              input int ea, input int ha);
        a_mat    = a;
        b_mat    = b;
        err_adr  = ea;
        hang_adr = ha;
        clear_mon();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("accept_status", {busy, error, cyc, stb}, 4'b1011);
        check("first_req", {we, sel, adr}, {1'b1, 4'b0001, 32'd0});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL job_timeout: no done within %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [71:0] a;
        logic [71:0] b;
        int          err_adr;
        int          hang_adr;
        logic [71:0] exp_c;
        logic        exp_err;
        int          exp_xfers;
    } vec_t;

    task automatic check_job(input vec_t v);
        int bad = 0;
        check("done_pulses", done_cnt, 1);
        check("error", error, v.exp_err);
        check("c_mat", c_mat, v.exp_c);
        check("xfers", xfer_log.size(), v.exp_xfers);
        foreach (xfer_log[i]) if (xfer_log[i] != 32'(i)) bad++;
        check("adr_order", bad, 0);
        check("stb_rises", rises, v.exp_xfers + (v.exp_err ? 1 : 0));
        check("idle_bus", {busy, cyc, stb}, 0);
        if (v.hang_adr >= 0) check("timeout_len", last_stb_len, TO);
        else                 check("stb_len", last_stb_len, 2);
        if (!v.exp_err) check("cyc_cycles", cyc_cycles, 81);
    endtask

    localparam logic [71:0] ID   = 72'h010000000100000001;
    localparam logic [71:0] ID2  = 72'h020000000200000002;
    localparam logic [71:0] B19  = 72'h090807060504030201;
    localparam logic [71:0] TEN  = {9{8'h0A}};
    localparam logic [71:0] C44  = {9{8'h2C}};

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        logic [95:0] r;
        int          n;

        vecs[0] = '{ID,  B19, -1, -1, B19, 1'b0, 27};
        vecs[1] = '{TEN, TEN, -1, -1, C44, 1'b0, 27};
        vecs[2] = '{TEN, TEN,  4, -1, C44, 1'b1, 4};
        vecs[3] = '{TEN, TEN, -1, 18, C44, 1'b1, 18};
        vecs[4] = '{ID,  B19, -1, 22, 72'h2C2C2C2C2C04030201, 1'b1, 22};
        vecs[5] = '{ID2, B19, -1, -1, 72'h12100E0C0A08060402, 1'b0, 27};

        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_bus", {cyc, stb, we, sel, adr, dat_mosi}, 0);
        check("rst_status", {busy, done, error}, 0);
        check("rst_cmat", c_mat, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_rst", {busy, cyc, stb, done}, 0);

        // Table of jobs, run back to back (c_mat carries over on aborts).
        for (int i = 0; i < 6; i++) begin
            launch_job(vecs[i].a, vecs[i].b, vecs[i].err_adr, vecs[i].hang_adr);
            wait_done(1000);
            check_job(vecs[i]);
        end

        // Random operands against the matrix model.
        for (int j = 0; j < 8; j++) begin
            r = {$urandom(), $urandom(), $urandom()};
            v.a = r[71:0];
            r = {$urandom(), $urandom(), $urandom()};
            v.b = r[71:0];
            v.err_adr = -1; v.hang_adr = -1;
            v.exp_c = mat_mul(v.a, v.b); v.exp_err = 1'b0; v.exp_xfers = 27;
            launch_job(v.a, v.b, -1, -1);
            wait_done(1000);
            check_job(v);
        end

        // Reset asserted in the gap after write idx 7.
        launch_job(TEN, B19, -1, -1);
        n = 0;
        while (!(xfer_log.size() == 8 && cyc && !stb) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_wgap7", {xfer_log.size(), cyc, stb}, {32'd8, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        check("midjob_rst_bus", {cyc, stb, we, sel, adr, dat_mosi}, 0);
        check("midjob_rst_status", {busy, done, error}, 0);
        check("midjob_rst_cmat", c_mat, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_done_after_rst", done_cnt, 0);
        v = '{TEN, B19, -1, -1, mat_mul(TEN, B19), 1'b0, 27};
        launch_job(v.a, v.b, -1, -1);
        wait_done(1000);
        check_job(v);

        // Aborted job, then start pulsed during READ of the next one.
        launch_job(TEN, TEN, 4, -1);
        wait_done(1000);
        check("pre_error", error, 1'b1);
        launch_job(ID, B19, -1, -1);
        n = 0;
        while (!(stb && !we) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_read", {stb, we, sel}, {1'b1, 1'b0, 4'b1111});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1000);
        check_job('{ID, B19, -1, -1, B19, 1'b0, 27});
        repeat (20) @(negedge clk);
        check("no_rerun_xfers", xfer_log.size(), 27);
        check("no_rerun_done", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
